// File: rtl/partita_ctrl_if.sv
// rtl/partita_ctrl_if.sv - player handshakes and engine link of the match controller
interface partita_ctrl_if;
    logic [1:0] P1_MOVE;
    logic       P1_VALID;
    logic       P1_READY;
    logic [1:0] P2_MOVE;
    logic       P2_VALID;
    logic       P2_READY;
    logic [1:0] ENG_PRIMO;
    logic [1:0] ENG_SECONDO;
    logic       ENG_INIZIA;
    logic [1:0] ENG_MANCHE;
    logic [1:0] ENG_PARTITA;

    modport master (
        output P1_MOVE, P1_VALID, P2_MOVE, P2_VALID, ENG_MANCHE, ENG_PARTITA,
        input  P1_READY, P2_READY, ENG_PRIMO, ENG_SECONDO, ENG_INIZIA
    );

    modport slave (
        input  P1_MOVE, P1_VALID, P2_MOVE, P2_VALID, ENG_MANCHE, ENG_PARTITA,
        output P1_READY, P2_READY, ENG_PRIMO, ENG_SECONDO, ENG_INIZIA
    );
endinterface

// File: rtl/partita_ctrl.sv
// rtl/partita_ctrl.sv - rock-paper-scissors match controller: move pairing, engine issue, timeout, scoreboard
module partita_ctrl #(
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    partita_ctrl_if.slave    bus,
    output logic             BUSY,
    output logic [1:0]       LAST_MANCHE,
    output logic             DONE,
    output logic [1:0]       RESULT,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] WINS_P1,
    output logic [CNT_W-1:0] WINS_P2,
    output logic [CNT_W-1:0] DRAWS
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_COLLECT, S_ISSUE, S_WAIT, S_END
    } state_t;

    state_t          state;
    logic            full1, full2;
    logic [1:0]      slot1, slot2;
    logic [TO_W-1:0] to_cnt;
    logic            take1, take2;

    assign bus.P1_READY = (state == S_COLLECT) && !full1;
    assign bus.P2_READY = (state == S_COLLECT) && !full2;
    assign BUSY         = (state != S_IDLE);

    // A 00 move completes the handshake but never fills the slot.
    assign take1 = bus.P1_VALID && bus.P1_READY && (bus.P1_MOVE != 2'b00);
    assign take2 = bus.P2_VALID && bus.P2_READY && (bus.P2_MOVE != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            full1           <= 1'b0;
            full2           <= 1'b0;
            slot1           <= 2'b00;
            slot2           <= 2'b00;
            to_cnt          <= '0;
            bus.ENG_PRIMO   <= 2'b00;
            bus.ENG_SECONDO <= 2'b00;
            bus.ENG_INIZIA  <= 1'b0;
            LAST_MANCHE     <= 2'b00;
            DONE            <= 1'b0;
            RESULT          <= 2'b00;
            TIMEOUT         <= 1'b0;
            WINS_P1         <= '0;
            WINS_P2         <= '0;
            DRAWS           <= '0;
        end else begin
            bus.ENG_INIZIA  <= 1'b0;
            bus.ENG_PRIMO   <= 2'b00;
            bus.ENG_SECONDO <= 2'b00;
            DONE            <= 1'b0;
            TIMEOUT         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state          <= S_INIT;
                        bus.ENG_INIZIA <= 1'b1;
                        RESULT         <= 2'b00;
                    end
                end
                S_INIT: state <= S_COLLECT;
                S_COLLECT: begin
                    if (take1) begin
                        full1 <= 1'b1;
                        slot1 <= bus.P1_MOVE;
                    end
                    if (take2) begin
                        full2 <= 1'b1;
                        slot2 <= bus.P2_MOVE;
                    end
                    // A completed pair wins over a timeout expiring on the same edge.
                    if ((full1 || take1) && (full2 || take2)) begin
                        state           <= S_ISSUE;
                        bus.ENG_PRIMO   <= take1 ? bus.P1_MOVE : slot1;
                        bus.ENG_SECONDO <= take2 ? bus.P2_MOVE : slot2;
                    end else if (full1 != full2) begin
                        if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            state   <= S_END;
                            DONE    <= 1'b1;
                            TIMEOUT <= 1'b1;
                            RESULT  <= full1 ? 2'b01 : 2'b10;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    LAST_MANCHE <= bus.ENG_MANCHE;
                    full1       <= 1'b0;
                    full2       <= 1'b0;
                    to_cnt      <= '0;
                    if (bus.ENG_PARTITA != 2'b00) begin
                        RESULT <= bus.ENG_PARTITA;
                        DONE   <= 1'b1;
                        state  <= S_END;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                S_END: begin
                    case (RESULT)
                        2'b01:   if (WINS_P1 != '1) WINS_P1 <= WINS_P1 + 1'b1;
                        2'b10:   if (WINS_P2 != '1) WINS_P2 <= WINS_P2 + 1'b1;
                        2'b11:   if (DRAWS != '1)   DRAWS   <= DRAWS + 1'b1;
                        default: ;
                    endcase
                    full1  <= 1'b0;
                    full2  <= 1'b0;
                    to_cnt <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
